// File: rtl/rate_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : rate_tick_gen
// Description : Selectable-period enable strobe with run / pause / single-step
//               control, feeding the enable input of downstream counters.
// Revision    : 1.0 - initial release
// ============================================================================
module rate_tick_gen #(
    parameter int WIDTH   = 28,
    parameter int PERIOD0 = 1,
    parameter int PERIOD1 = 50_000_000,
    parameter int PERIOD2 = 100_000_000,
    parameter int PERIOD3 = 200_000_000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             run,
    input  logic             step,
    input  logic [1:0]       speed,
    output logic             tick,
    output logic [1:0]       state,
    output logic [WIDTH-1:0] count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10
    } state_t;

    localparam logic [WIDTH-1:0] C_RELOAD0 = WIDTH'(PERIOD0 - 1);
    localparam logic [WIDTH-1:0] C_RELOAD1 = WIDTH'(PERIOD1 - 1);
    localparam logic [WIDTH-1:0] C_RELOAD2 = WIDTH'(PERIOD2 - 1);
    localparam logic [WIDTH-1:0] C_RELOAD3 = WIDTH'(PERIOD3 - 1);
    localparam logic [WIDTH-1:0] C_ONE     = WIDTH'(1);

    state_t           r_state;
    state_t           w_state_nx;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nx;
    logic [1:0]       r_speed_q;
    logic [1:0]       w_speed_nx;
    logic             r_tick;
    logic             w_tick_nx;
    logic             r_step_d;
    logic             w_step_edge;

    function automatic logic [WIDTH-1:0] f_reload(input logic [1:0] sel);
        case (sel)
            2'd0:    f_reload = C_RELOAD0;
            2'd1:    f_reload = C_RELOAD1;
            2'd2:    f_reload = C_RELOAD2;
            default: f_reload = C_RELOAD3;
        endcase
    endfunction

    assign w_step_edge = step & ~r_step_d;

    always_comb begin
        w_state_nx = r_state;
        w_count_nx = r_count;
        w_speed_nx = r_speed_q;
        w_tick_nx  = 1'b0;

        case (r_state)
            S_IDLE:  if (run)  w_state_nx = S_RUN;
            S_RUN:   if (!run) w_state_nx = S_PAUSE;
            S_PAUSE: if (run)  w_state_nx = S_RUN;
            default:           w_state_nx = S_IDLE;
        endcase

        if (clr) begin
            w_state_nx = S_IDLE;
            w_count_nx = f_reload(speed);
            w_speed_nx = speed;
        end else if (speed != r_speed_q) begin
            // Reload suppresses any expiry, but a manual step still gets through
            w_speed_nx = speed;
            w_count_nx = f_reload(speed);
            w_tick_nx  = w_step_edge && ((r_state == S_IDLE) || (r_state == S_PAUSE));
        end else begin
            case (r_state)
                S_RUN: begin
                    if (run) begin
                        if (r_count == '0) begin
                            w_tick_nx  = 1'b1;
                            w_count_nx = f_reload(r_speed_q);
                        end else begin
                            w_count_nx = r_count - C_ONE;
                        end
                    end
                end
                S_IDLE, S_PAUSE: w_tick_nx = w_step_edge;
                default:         w_tick_nx = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_count   <= C_RELOAD0;
            r_speed_q <= 2'd0;
            r_tick    <= 1'b0;
            r_step_d  <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_count   <= w_count_nx;
            r_speed_q <= w_speed_nx;
            r_tick    <= w_tick_nx;
            r_step_d  <= step;
        end
    end

    assign tick  = r_tick;
    assign state = r_state;
    assign count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_rate_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_rate_tick_gen
// Description : Scoreboard bench for rate_tick_gen with a cycle reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rate_tick_gen;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset_n;
    logic             clr;
    logic             run;
    logic             step;
    logic [1:0]       speed;
    logic             tick;
    logic [1:0]       state;
    logic [WIDTH-1:0] count;

    rate_tick_gen #(
        .WIDTH   (WIDTH),
        .PERIOD0 (1),
        .PERIOD1 (4),
        .PERIOD2 (6),
        .PERIOD3 (10)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (clr),
        .run     (run),
        .step    (step),
        .speed   (speed),
        .tick    (tick),
        .state   (state),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       tick;
        logic [1:0] st;
        logic [7:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Reference model: 0=IDLE 1=RUN 2=PAUSE
    int period [4] = '{1, 4, 6, 10};
    int m_state   = 0;
    int m_count   = 0;
    int m_speed_q = 0;
    int m_tick    = 0;
    int m_step_d  = 0;

    task automatic model(input logic rn, input logic c, input logic r, input logic s, input logic [1:0] sp);
        int ns;
        int edge_seen;
        if (!rn) begin
            m_state = 0; m_count = period[0] - 1; m_speed_q = 0; m_tick = 0; m_step_d = 0;
        end else begin
            edge_seen = (s && !m_step_d) ? 1 : 0;
            if (c) begin
                m_state = 0; m_count = period[sp] - 1; m_speed_q = int'(sp); m_tick = 0;
            end else begin
                ns = m_state;
                if (m_state == 0 && r) ns = 1;
                else if (m_state == 1 && !r) ns = 2;
                else if (m_state == 2 && r) ns = 1;
                if (int'(sp) != m_speed_q) begin
                    m_speed_q = int'(sp);
                    m_count   = period[sp] - 1;
                    m_tick    = (m_state != 1) ? edge_seen : 0;
                end else if (m_state == 1) begin
                    m_tick = 0;
                    if (r) begin
                        if (m_count == 0) begin
                            m_tick  = 1;
                            m_count = period[m_speed_q] - 1;
                        end else begin
                            m_count = m_count - 1;
                        end
                    end
                end else begin
                    m_tick = edge_seen;
                end
                m_state = ns;
            end
            m_step_d = s ? 1 : 0;
        end
    endtask

    task automatic drive(input logic rn, input logic c, input logic r, input logic s, input logic [1:0] sp);
        exp_t e;
        @(negedge clk);
        reset_n = rn; clr = c; run = r; step = s; speed = sp;
        model(rn, c, r, s, sp);
        e.tick = (m_tick != 0);
        e.st   = 2'(m_state);
        e.cnt  = 8'(m_count);
        q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h required %0h", nm, $time, act, req);
        end
    endtask

    task automatic guard_fail(input string nm);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: cycle budget expired", nm);
    endtask

    // Monitor: every edge presents tick/state/count; compare with the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("tick",  32'(tick),  32'(e.tick));
                chk("state", 32'(state), 32'(e.st));
                chk("count", 32'(count), 32'(e.cnt));
            end
        end
    end

    initial begin
        #200000;
        guard_fail("watchdog");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        int   g;
        logic rl, sl, rnd_rn, rnd_c;
        logic [1:0] sp;
        reset_n = 1'b0; clr = 1'b0; run = 1'b0; step = 1'b0; speed = 2'd0;
        m_count = period[0] - 1;

        // Reset then free-run at P=1
        repeat (3) drive(0, 0, 0, 0, 0);
        repeat (10) drive(1, 0, 1, 0, 0);

        // Speed 1 free-run from IDLE
        drive(1, 1, 0, 0, 1);
        repeat (25) drive(1, 0, 1, 0, 1);

        // Pause / resume at speed 2
        drive(1, 1, 0, 0, 2);
        repeat (5) drive(1, 0, 1, 0, 2);
        repeat (10) drive(1, 0, 0, 0, 2);
        repeat (8) drive(1, 0, 1, 0, 2);

        // Single step in PAUSE, then a step in RUN
        repeat (2) drive(1, 0, 0, 0, 2);
        repeat (5) drive(1, 0, 0, 1, 2);
        repeat (3) drive(1, 0, 0, 0, 2);
        repeat (3) drive(1, 0, 1, 0, 2);
        drive(1, 0, 1, 1, 2);
        repeat (14) drive(1, 0, 1, 0, 2);

        // Speed change coinciding with expiry
        drive(1, 1, 0, 0, 1);
        g = 0;
        while (!(m_state == 1 && m_count == 0) && g < 50) begin
            drive(1, 0, 1, 0, 1);
            g++;
        end
        if (g >= 50) guard_fail("reach_expiry");
        drive(1, 0, 1, 0, 3);
        repeat (12) drive(1, 0, 1, 0, 3);

        // clr mid-count, then reset while expiry pending
        g = 0;
        while (!(m_state == 1 && m_count == 2) && g < 50) begin
            drive(1, 0, 1, 0, 3);
            g++;
        end
        if (g >= 50) guard_fail("reach_count2");
        drive(1, 1, 1, 0, 3);
        g = 0;
        while (!(m_state == 1 && m_count == 0) && g < 50) begin
            drive(1, 0, 1, 0, 3);
            g++;
        end
        if (g >= 50) guard_fail("reach_zero");
        drive(0, 0, 1, 0, 3);
        repeat (3) drive(1, 0, 0, 0, 0);

        // Randomized traffic
        rl = 1'b0; sl = 1'b0; sp = 2'd0;
        for (int i = 0; i < 500; i++) begin
            rnd_rn = ($urandom_range(0, 49) != 0);
            rnd_c  = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 7) == 0)  rl = ~rl;
            if ($urandom_range(0, 3) == 0)  sl = ~sl;
            if ($urandom_range(0, 19) == 0) sp = 2'($urandom_range(0, 3));
            drive(rnd_rn, rnd_c, rl, sl, sp);
        end

        repeat (2) @(posedge clk);
        #2;
        chk("drain", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
